// File: rtl/sound_pkg.sv
// Shared constants and the per-side mix arithmetic for the sound output path.
// Imported by the mixer top and the I2S serializer.
package sound_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int LEVEL_W     = 4;
  localparam int SLOT_W      = 5;
  localparam int SUM_W       = 6;
  localparam int PROD_W      = 9;
  localparam int VOL_W       = 3;
  localparam int FRAME_W     = 2 * SAMPLE_W;

  // NR51 routing bit positions
  localparam int R_CH1 = 0;
  localparam int R_CH2 = 1;
  localparam int R_CH3 = 2;
  localparam int R_CH4 = 3;
  localparam int L_CH1 = 4;
  localparam int L_CH2 = 5;
  localparam int L_CH3 = 6;
  localparam int L_CH4 = 7;

  // NR50 master volume field positions (3-bit fields)
  localparam int NR50_R_LSB = 0;
  localparam int NR50_L_LSB = 4;

  function automatic logic signed [SUM_W-1:0] sext_level(input logic [LEVEL_W-1:0] lv);
    return signed'({{(SUM_W-LEVEL_W){lv[LEVEL_W-1]}}, lv});
  endfunction

  // en[0] routes ch1 .. en[3] routes ch4; result is {prod, 7'b0}.
  function automatic logic [SAMPLE_W-1:0] mix_side(
    input logic [LEVEL_W-1:0] l1,
    input logic [LEVEL_W-1:0] l2,
    input logic [LEVEL_W-1:0] l3,
    input logic [LEVEL_W-1:0] l4,
    input logic [3:0]         en,
    input logic [VOL_W-1:0]   vol
  );
    logic signed [SUM_W-1:0]  sum;
    logic signed [PROD_W-1:0] sum_x;
    logic signed [PROD_W-1:0] gain;
    logic signed [PROD_W-1:0] prod;
    sum = '0;
    if (en[0]) sum = sum + sext_level(l1);
    if (en[1]) sum = sum + sext_level(l2);
    if (en[2]) sum = sum + sext_level(l3);
    if (en[3]) sum = sum + sext_level(l4);
    sum_x = PROD_W'(sum);
    gain  = signed'(PROD_W'(vol)) + PROD_W'(1);
    // Worst case -32*8 = -256 still fits the 9-bit product.
    prod  = sum_x * gain;
    return {prod, {(SAMPLE_W-PROD_W){1'b0}}};
  endfunction

endpackage

// File: rtl/sound_i2s_tx.sv
// I2S serializer: BCLK divider, 32-slot frame counter, shift register and
// LRCK/SDATA generation with the standard one-BCLK data delay.
module sound_i2s_tx
  import sound_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] frame_l,
  input  logic [SAMPLE_W-1:0] frame_r,
  output logic                frame_load,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_sdata
);

  logic [7:0]         div;
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  next_slot;
  logic               started;
  logic [FRAME_W-1:0] sr;
  logic               terminal;
  logic               falling;

  // After reset the first falling event is itself a frame boundary, so the
  // first frame begins at slot 0 instead of slot 1.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    terminal   = (div == 8'(BCLK_DIV - 1));
    falling    = terminal && i2s_bclk;
    frame_load = falling && (!started || slot == SLOT_W'(FRAME_SLOTS - 1));
    next_slot  = started ? slot + SLOT_W'(1) : '0;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div       <= '0;
      slot      <= '0;
      started   <= 1'b0;
      sr        <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      if (terminal) begin
        div      <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div <= div + 8'd1;
      end
      if (falling) begin
        slot      <= next_slot;
        started   <= 1'b1;
        i2s_sdata <= sr[FRAME_W-1];
        i2s_lrck  <= next_slot[SLOT_W-1];
        sr        <= frame_load ? {frame_l, frame_r} : {sr[FRAME_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sound_mixer_dac.sv
// Sound output stage: routes and scales the four channel levels per side,
// latches one L/R frame per I2S frame and serializes it to the DAC.
module sound_mixer_dac
  import sound_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sound_enable,
  input  logic [3:0]  ch1_level,
  input  logic [3:0]  ch2_level,
  input  logic [3:0]  ch3_level,
  input  logic [3:0]  ch4_level,
  input  logic [7:0]  nr51,
  input  logic [7:0]  nr50,
  output logic        sample_strobe,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata
);

  logic [SAMPLE_W-1:0] mix_l;
  logic [SAMPLE_W-1:0] mix_r;
  logic [3:0]          route_l;
  logic [3:0]          route_r;
  logic                frame_load;

  assign route_l = {nr51[L_CH4], nr51[L_CH3], nr51[L_CH2], nr51[L_CH1]};
  assign route_r = {nr51[R_CH4], nr51[R_CH3], nr51[R_CH2], nr51[R_CH1]};

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mix_l <= '0;
      mix_r <= '0;
    end else if (!sound_enable) begin
      mix_l <= '0;
      mix_r <= '0;
    end else begin
      mix_l <= mix_side(ch1_level, ch2_level, ch3_level, ch4_level, route_l,
                        nr50[NR50_L_LSB +: VOL_W]);
      mix_r <= mix_side(ch1_level, ch2_level, ch3_level, ch4_level, route_r,
                        nr50[NR50_R_LSB +: VOL_W]);
    end
  end

  // Published samples change only together with the serializer's frame load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_strobe <= 1'b0;
      sample_l      <= '0;
      sample_r      <= '0;
    end else begin
      sample_strobe <= frame_load;
      if (frame_load) begin
        sample_l <= mix_l;
        sample_r <= mix_r;
      end
    end
  end

  sound_i2s_tx #(
    .BCLK_DIV (BCLK_DIV)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .frame_l    (mix_l),
    .frame_r    (mix_r),
    .frame_load (frame_load),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata)
  );

endmodule
